mc_capture_ctrl: RTL and testbench

MC_CAPTURE_CTRL -- requirements
Module: mc_capture_ctrl

---
 rtl/adc_cap_pkg.sv | 16 +
 rtl/chan_serializer.sv | 84 ++++++++
 rtl/mc_capture_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg -- shared types and constants for the ADC capture controller.
//   cap_state_e : FSM encoding, also exported on the 3-bit debug state port.
//   MAX_CH      : largest supported channel count.
//   CH_IDX_W    : width of a channel index (dout_ch, trig_ch).
package adc_cap_pkg;
  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;
endpackage

// File: rtl/chan_serializer.sv
// chan_serializer -- holds one latched sample set and emits the enabled
// channels one word per cycle in ascending index order.
//   clk/rstn      : clock, async active-low reset
//   clr_i         : drop any pending words
//   load_i        : latch set_i with mask_i (only when busy_o is low)
//   load_last_i   : the set being loaded is the final set of the record
//   stall_i       : hold position, no write this cycle
//   wr_en_o/dout_o/dout_ch_o/last_o : write strobe, sign-extended word,
//                   channel index, final word of record
//   busy_o        : cannot accept a new set at this clock edge
module chan_serializer
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADC_W  = 14,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    load_last_i,
  input  logic [NUM_CH*ADC_W-1:0] set_i,
  input  logic [NUM_CH-1:0]       mask_i,
  input  logic                    stall_i,
  output logic                    wr_en_o,
  output logic [OUT_W-1:0]        dout_o,
  output logic [CH_IDX_W-1:0]     dout_ch_o,
  output logic                    last_o,
  output logic                    busy_o
);
  logic [NUM_CH*ADC_W-1:0] set_q;
  logic [NUM_CH-1:0]       pend_q, pend_d, pick;
  logic                    last_set_q;
  logic [CH_IDX_W-1:0]     cur;
  logic signed [ADC_W-1:0] smp;
  logic                    adv, final_word;

  // Lowest pending channel wins; descending loop leaves the lowest in place.
  always_comb begin
    cur  = '0;
    pick = '0;
    smp  = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (pend_q[c]) begin
        cur     = CH_IDX_W'(c);
        pick    = '0;
        pick[c] = 1'b1;
        smp     = set_q[c*ADC_W +: ADC_W];
      end
    end
  end

  assign adv        = (|pend_q) & ~stall_i;
  assign final_word = ((pend_q & ~pick) == '0);
  assign wr_en_o    = adv;
  assign dout_o     = OUT_W'(smp);  // signed cast sign-extends
  assign dout_ch_o  = cur;
  assign last_o     = adv & final_word & last_set_q;
  // A set arriving on the edge that retires the last word is accepted, so a
  // back-to-back stream has no bubble.
  assign busy_o     = (|pend_q) & ~(adv & final_word);

  always_comb begin
    pend_d = pend_q;
    if (clr_i)       pend_d = '0;
    else if (load_i) pend_d = mask_i;
    else if (adv)    pend_d = pend_q & ~pick;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      set_q      <= '0;
      pend_q     <= '0;
      last_set_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (load_i && !clr_i) begin
        set_q      <= set_i;
        last_set_q <= load_last_i;
      end
    end
  end
endmodule

// File: rtl/mc_capture_ctrl.sv
// mc_capture_ctrl -- multi-channel ADC record capture into a downstream FIFO.
//   clk, rstn            : clock, async active-low reset
//   adc_din/adc_en       : packed samples (ch0 in LSBs) and valid
//   ch_mask/decim/rec_len: record config, latched on start
//   start                : capture request pulse (IDLE only)
//   fifo_rst/full        : downstream FIFO reset-busy and full
//   trig_ch/trig_level   : trigger source and signed threshold
//   wr_en/dout/dout_ch/last : FIFO write port
//   busy/done/overflow/state: status
// Build option: CAP_TRIG_EN -- ARMED waits for a rising threshold crossing on
// trig_ch; without it ARMED lasts one cycle and the trigger ports are unused.
module mc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADC_W  = 14,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH*ADC_W-1:0] adc_din,
  input  logic                    adc_en,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [7:0]              decim,
  input  logic [LEN_W-1:0]        rec_len,
  input  logic                    start,
  input  logic                    fifo_rst,
  input  logic                    full,
  input  logic [2:0]              trig_ch,
  input  logic [ADC_W-1:0]        trig_level,
  output logic                    wr_en,
  output logic [OUT_W-1:0]        dout,
  output logic [2:0]              dout_ch,
  output logic                    last,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [2:0]              state
);
  cap_state_e        state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        decim_q, dec_cnt_q, decim_eff, dec_cnt_nxt;
  logic [LEN_W-1:0]  len_q, set_cnt_q;
  logic              done_q, ovf_q;
  logic              abort, cap_slot, trig_hit, ser_load, last_set;
  logic              ser_busy, ser_wr, ser_last;

  assign decim_eff   = (decim_q == 8'd0) ? 8'd1 : decim_q;
  assign dec_cnt_nxt = (dec_cnt_q + 8'd1 == decim_eff) ? 8'd0 : dec_cnt_q + 8'd1;
  assign last_set    = ((set_cnt_q + LEN_W'(1)) == len_q);
  assign abort       = fifo_rst && (state_q == ST_ARMED || state_q == ST_CAPTURE ||
                                    state_q == ST_DRAIN);
  assign cap_slot    = (state_q == ST_CAPTURE) && adc_en && (dec_cnt_q == 8'd0) && !fifo_rst;
  assign ser_load    = trig_hit | (cap_slot & ~ser_busy);

`ifdef CAP_TRIG_EN
  logic [2:0]              trig_ch_q;
  logic signed [ADC_W-1:0] trig_lvl_q, prev_q, trig_smp;
  logic                    prev_vld_q;

  always_comb begin
    trig_smp = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (trig_ch_q == 3'(c)) trig_smp = adc_din[c*ADC_W +: ADC_W];
  end

  assign trig_hit = (state_q == ST_ARMED) && adc_en && !fifo_rst && prev_vld_q &&
                    (prev_q < trig_lvl_q) && (trig_smp >= trig_lvl_q);
`else
  logic unused_trig;
  assign unused_trig = ^{trig_ch, trig_level};
  assign trig_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mask_q    <= '0;
      decim_q   <= '0;
      len_q     <= '0;
      dec_cnt_q <= '0;
      set_cnt_q <= '0;
`ifdef CAP_TRIG_EN
      trig_ch_q  <= '0;
      trig_lvl_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start && !fifo_rst) begin
          mask_q    <= ch_mask;
          decim_q   <= decim;
          len_q     <= rec_len;
          ovf_q     <= 1'b0;
          set_cnt_q <= '0;
          dec_cnt_q <= '0;
`ifdef CAP_TRIG_EN
          trig_ch_q  <= trig_ch;
          trig_lvl_q <= trig_level;
          prev_vld_q <= 1'b0;
`endif
          if (ch_mask == '0 || rec_len == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: if (fifo_rst) state_q <= ST_IDLE;
        else begin
`ifdef CAP_TRIG_EN
          if (adc_en) begin
            prev_q     <= trig_smp;
            prev_vld_q <= 1'b1;
          end
          // The crossing set itself is the first captured set.
          if (trig_hit) begin
            set_cnt_q <= set_cnt_q + LEN_W'(1);
            dec_cnt_q <= dec_cnt_nxt;
            state_q   <= last_set ? ST_DRAIN : ST_CAPTURE;
          end
`else
          state_q <= ST_CAPTURE;
`endif
        end
        ST_CAPTURE: if (fifo_rst) state_q <= ST_IDLE;
        else if (adc_en) begin
          dec_cnt_q <= dec_cnt_nxt;
          if (dec_cnt_q == 8'd0) begin
            if (ser_busy) ovf_q <= 1'b1;  // dropped set is not counted
            else begin
              set_cnt_q <= set_cnt_q + LEN_W'(1);
              if (last_set) state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: if (fifo_rst) state_q <= ST_IDLE;
        else if (ser_wr && ser_last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  chan_serializer #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .OUT_W(OUT_W)) u_ser (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (abort),
    .load_i     (ser_load),
    .load_last_i(last_set),
    .set_i      (adc_din),
    .mask_i     (mask_q),
    .stall_i    (full | fifo_rst),
    .wr_en_o    (ser_wr),
    .dout_o     (dout),
    .dout_ch_o  (dout_ch),
    .last_o     (ser_last),
    .busy_o     (ser_busy)
  );

  assign wr_en    = ser_wr;
  assign last     = ser_last;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign state    = state_q;
endmodule

// File: tb/tb_mc_capture_ctrl.sv
// Directed bench for mc_capture_ctrl (NUM_CH=4, ADC_W=14, OUT_W=16).
module tb_mc_capture_ctrl;
  logic        clk, rstn;
  logic [55:0] adc_din;
  logic        adc_en;
  logic [3:0]  ch_mask;
  logic [7:0]  decim;
  logic [15:0] rec_len;
  logic        start, fifo_rst, full;
  logic [2:0]  trig_ch;
  logic [13:0] trig_level;
  logic        wr_en, last, busy, done, overflow;
  logic [15:0] dout;
  logic [2:0]  dout_ch, state;

  int n_chk = 0;
  int n_err = 0;

  mc_capture_ctrl #(.NUM_CH(4), .ADC_W(14), .OUT_W(16), .LEN_W(16)) dut (
    .clk(clk), .rstn(rstn), .adc_din(adc_din), .adc_en(adc_en), .ch_mask(ch_mask),
    .decim(decim), .rec_len(rec_len), .start(start), .fifo_rst(fifo_rst), .full(full),
    .trig_ch(trig_ch), .trig_level(trig_level), .wr_en(wr_en), .dout(dout),
    .dout_ch(dout_ch), .last(last), .busy(busy), .done(done), .overflow(overflow),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  decim;
    logic [15:0] len;
    int          stall_at;  // write count at which full goes high for 5 cycles
    int          abort_at;  // write count at which fifo_rst pulses
    bit          perturb;   // change config and pulse start mid-capture
    int          exp_wr;
    bit          exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Sample value of channel c at valid-cycle t; ch2/ch3 are negative.
  function automatic logic [13:0] pat(input int t, input int c);
    return 14'(c * 4096 + t * 3);
  endfunction

  function automatic logic [55:0] set_word(input int t);
    return {pat(t, 3), pat(t, 2), pat(t, 1), pat(t, 0)};
  endfunction

  function automatic logic [15:0] sx(input logic [13:0] s);
    return {{2{s[13]}}, s};
  endfunction

  task automatic idle_inputs();
    adc_en = 1'b0; start = 1'b0; fifo_rst = 1'b0; full = 1'b0;
  endtask

  task automatic run_rec(input vec_t v, input string nm);
    int n, d0, last_acc, t, acc, cyc, done_cnt, done_cyc, last_wcyc, abort_cyc, stall_left;
    bit stalled, fin;
    logic [2:0]  ech[$], gch[$];
    logic [15:0] edat[$], gdat[$];
    bit          elast[$], glast[$];
    // Expected word stream: a slot is accepted only if the previous set has
    // had popcount(mask) cycles to drain.
    n = $countones(v.mask);
    d0 = (v.decim == 0) ? 1 : int'(v.decim);
    if (n > 0 && v.len > 0) begin
      last_acc = -1000; t = 0; acc = 0;
      while (acc < int'(v.len)) begin
        if (t - last_acc >= n) begin
          for (int c = 0; c < 4; c++)
            if (v.mask[c]) begin
              ech.push_back(3'(c)); edat.push_back(sx(pat(t, c))); elast.push_back(1'b0);
            end
          last_acc = t; acc++;
        end
        t += d0;
      end
      elast[elast.size()-1] = 1'b1;
    end
    @(posedge clk); #1;
    ch_mask = v.mask; decim = v.decim; rec_len = v.len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; done_cnt = 0; done_cyc = -1; last_wcyc = -1; abort_cyc = -1;
    stall_left = 0; stalled = 0; fin = 0;
    while (!fin) begin
      adc_en = (cyc >= 1);
      if (cyc >= 1) adc_din = set_word(cyc - 1);
      if (v.perturb && cyc == 3) begin
        ch_mask = 4'b0001; decim = 8'd1; rec_len = 16'd1; start = 1'b1;
      end else start = 1'b0;
      if (!stalled && v.stall_at >= 0 && gch.size() == v.stall_at) begin
        stalled = 1; stall_left = 5;
      end
      full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      fifo_rst = (v.abort_at >= 0 && abort_cyc < 0 && gch.size() == v.abort_at);
      if (fifo_rst) abort_cyc = cyc;
      @(negedge clk);
      if (full) chk({nm, " stall_wr"}, 32'(wr_en), 0);
      if (fifo_rst) chk({nm, " abort_wr"}, 32'(wr_en), 0);
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        chk({nm, " abort_state"}, 32'(state), 0);
        chk({nm, " abort_busy"}, 32'(busy), 0);
      end
      if (wr_en) begin
        gch.push_back(dout_ch); gdat.push_back(dout); glast.push_back(last); last_wcyc = cyc;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk({nm, " done_state"}, 32'(state), 4);
      end
      fin = (done_cnt > 0 && cyc >= done_cyc + 3) ||
            (abort_cyc >= 0 && cyc >= abort_cyc + 10) || cyc >= 400;
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    chk({nm, " ended"}, 32'(done_cnt > 0 || abort_cyc >= 0), 1);
    chk({nm, " nwr"}, 32'(gch.size()), 32'(v.exp_wr));
    chk({nm, " ovf"}, 32'(overflow), 32'(v.exp_ovf));
    chk({nm, " ndone"}, 32'(done_cnt), (v.abort_at >= 0) ? 0 : 1);
    chk({nm, " idle"}, 32'({busy, state}), 0);
    for (int i = 0; i < gch.size() && i < ech.size(); i++) begin
      chk($sformatf("%s w%0d ch", nm, i), 32'(gch[i]), 32'(ech[i]));
      chk($sformatf("%s w%0d dat", nm, i), 32'(gdat[i]), 32'(edat[i]));
      chk($sformatf("%s w%0d last", nm, i), 32'(glast[i]), 32'(elast[i]));
    end
    if (v.abort_at < 0)
      chk({nm, " done_lat"}, 32'(done_cyc), (v.exp_wr == 0) ? 0 : 32'(last_wcyc + 1));
  endtask

  vec_t tbl[12];
  int   wcnt, bound;

  initial begin
    tbl[0]  = '{4'b1111, 8'd4,  16'd3, -1, -1, 0, 12, 0};
    tbl[1]  = '{4'b1010, 8'd2,  16'd2, -1, -1, 0, 4,  0};
    tbl[2]  = '{4'b1111, 8'd1,  16'd4, -1, -1, 0, 16, 1};
    tbl[3]  = '{4'b0110, 8'd1,  16'd3, -1, -1, 0, 6,  1};
    tbl[4]  = '{4'b0000, 8'd2,  16'd3, -1, -1, 0, 0,  0};
    tbl[5]  = '{4'b0001, 8'd0,  16'd5, -1, -1, 0, 5,  0};
    tbl[6]  = '{4'b1000, 8'd3,  16'd1, -1, -1, 0, 1,  0};
    tbl[7]  = '{4'b1111, 8'd12, 16'd2,  2, -1, 0, 8,  0};
    tbl[8]  = '{4'b1111, 8'd4,  16'd3, -1, -1, 1, 12, 0};
    tbl[9]  = '{4'b1111, 8'd4,  16'd8, -1,  5, 0, 5,  0};
    tbl[10] = '{4'b1111, 8'd4,  16'd3, -1, -1, 0, 12, 0};
    tbl[11] = '{4'b0101, 8'd5,  16'd0, -1, -1, 0, 0,  0};

    rstn = 1'b0; adc_din = '0; ch_mask = '0; decim = '0; rec_len = '0;
    trig_ch = '0; trig_level = '0;
    idle_inputs();
    #12;
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst flags", 32'({last, busy, done, overflow}), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst dout_ch", 32'(dout_ch), 0);
    chk("rst state", 32'(state), 0);
    @(negedge clk); rstn = 1'b1;

`ifdef CAP_TRIG_EN
    // Ramp ch0 from -50 in steps of 25; capture must begin at the 100 sample.
    @(posedge clk); #1;
    ch_mask = 4'b0001; decim = 8'd1; rec_len = 16'd1; trig_ch = 3'd0;
    trig_level = 14'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      int v; logic [13:0] s;
      v = -50 + 25 * ((k > 10) ? 10 : k);
      s = 14'(v);
      adc_en = 1'b1; adc_din = {42'd0, s};
      @(negedge clk);
      if (wr_en) begin
        wcnt++;
        if (wcnt == 1) begin
          chk("trig first", 32'(dout), 32'h0064);
          chk("trig last", 32'(last), 1);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("trig nwr", 32'(wcnt), 1);
`else
    // start while the FIFO is in reset is ignored
    @(posedge clk); #1;
    ch_mask = 4'b1111; decim = 8'd1; rec_len = 16'd2; fifo_rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; fifo_rst = 1'b0;
    @(negedge clk);
    chk("fiforst start state", 32'(state), 0);
    chk("fiforst start busy", 32'(busy), 0);

    for (int i = 0; i < 12; i++) run_rec(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-record: outputs drop at once and the record is discarded.
    @(posedge clk); #1;
    ch_mask = 4'b1111; decim = 8'd4; rec_len = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wcnt = 0; bound = 0;
    while (wcnt < 3 && bound < 50) begin
      adc_en = 1'b1; adc_din = set_word(bound);
      @(negedge clk);
      if (wr_en) wcnt++;
      @(posedge clk); #1;
      bound++;
    end
    chk("rstmid reached", 32'(wcnt), 3);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid wr_en", 32'(wr_en), 0);
    chk("rstmid flags", 32'({last, busy, done, overflow}), 0);
    chk("rstmid dout", 32'({dout, 13'd0, dout_ch}), 0);
    chk("rstmid state", 32'(state), 0);
    @(negedge clk); rstn = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      adc_en = 1'b1; adc_din = set_word(k);
      @(negedge clk);
      if (wr_en) wcnt++;
    end
    idle_inputs();
    chk("rstmid no_wr", 32'(wcnt), 0);
    chk("rstmid idle", 32'(state), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
